// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES slices with a
// registered inter-slice carry, operand skew on entry and result deskew on exit.
module pipelined_rc_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int SW = WIDTH / STAGES;

  logic              en;
  logic [WIDTH-1:0]  yc;
  logic [STAGES:0]   c;
  logic [STAGES-1:0] v;
  logic              ovf_r;

  assign out_valid = v[STAGES-1];
  assign en        = !(out_valid && !out_ready);
  assign in_ready  = en;
  assign yc        = sub ? ~y : y;
  assign c[0]      = sub | cin;
  assign cout      = c[STAGES];
  assign ovf       = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (en) begin
      v[0] <= in_valid && in_ready;
      for (int unsigned k = 1; k < STAGES; k++) begin
        v[k] <= v[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    logic [SW-1:0] sum;
    logic [SW:0]   cc;
    logic          cr;
    logic [SW-1:0] sr [STAGES-k];

    if (k == 0) begin : g_direct
      assign a = x[0 +: SW];
      assign b = yc[0 +: SW];
    end else begin : g_skew
      // Slice k of the operands waits k cycles so it meets its own carry from stage k-1.
      logic [SW-1:0] xs [k];
      logic [SW-1:0] ys [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < k; i++) begin
            xs[i] <= '0;
            ys[i] <= '0;
          end
        end else if (en) begin
          xs[0] <= x[k*SW +: SW];
          ys[0] <= yc[k*SW +: SW];
          for (int unsigned i = 1; i < k; i++) begin
            xs[i] <= xs[i-1];
            ys[i] <= ys[i-1];
          end
        end
      end

      assign a = xs[k-1];
      assign b = ys[k-1];
    end

    always_comb begin
      cc    = '0;
      sum   = '0;
      cc[0] = c[k];
      for (int unsigned i = 0; i < SW; i++) begin
        sum[i]  = a[i] ^ b[i] ^ cc[i];
        cc[i+1] = (a[i] & b[i]) | (cc[i] & (a[i] ^ b[i]));
      end
    end

    // sr[0] is the stage's own result register; the rest realign slices on s.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cr <= 1'b0;
        for (int unsigned i = 0; i < STAGES-k; i++) begin
          sr[i] <= '0;
        end
      end else if (en) begin
        cr    <= cc[SW];
        sr[0] <= sum;
        for (int unsigned i = 1; i < STAGES-k; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign c[k+1]          = cr;
    assign s[k*SW +: SW]   = sr[STAGES-1-k];

    if (k == STAGES-1) begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (en) begin
          ovf_r <= cc[SW] ^ cc[SW-1];
        end
      end
    end
  end

endmodule
